lsu_bus_adapter: RTL and testbench
==================================

Name: lsu_bus_adapter

Overview:
- Load/store unit directly downstream of the instruction control decoder.
- Consumes the decoder's load type (3 bits) and store byte mask (4 bits), the ALU-computed address and rs2 data.
- Runs a multi-cycle valid/ready transaction on the data-memory bus, stalling the core until it completes.
- Returns sign- or zero-extended load data to the register-file write mux (its memory source input).

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, bus data width; fixed at 32 for RV32I, present for lint only.

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- mem_read_type  in  3  load type from decoder: MEM_RD_NONE/BYTE/HALF/WORD/B_U/H_U.
- mem_write_mask  in  4  unshifted store lane mask: none 0000, byte 0001, half 0011, word 1111.
- addr  in  32  effective address from ALU.
- wdata  in  32  rs2 value for stores.
- stall  out  1  freezes PC and pipeline while an access is in progress.
- load_data  out  32  extended load result.
- load_valid  out  1  load_data valid; one-cycle pulse.
- bus_addr  out  32  word-aligned address.
- bus_wdata  out  32  lane-replicated store data.
- bus_wstrb  out  4  byte strobes (0000 for loads).
- bus_we  out  1  1 = write.
- bus_valid  out  1  request valid.
- bus_ready  in  1  request accepted.
- bus_rdata  in  32  read data.
- bus_rvalid  in  1  read data valid.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: FSM enters IDLE; all outputs are 0.
- Operation detection:
  - An op is present when mem_read_type != MEM_RD_NONE or mem_write_mask != 0000.
  - If both are non-none, the read takes priority and the mask is ignored.
- States: IDLE, REQ, RESP, DONE.
- IDLE:
  - stall = op present (combinational).
  - When an op is present, latch type, mask, addr and wdata, then go to REQ.
- REQ:
  - bus_valid = 1, with bus_addr/bus_we/bus_wstrb/bus_wdata held stable from registers until bus_ready.
  - On bus_ready:
    - store -> DONE.
    - load with bus_rvalid in the same cycle -> capture data, go to DONE.
    - load otherwise -> RESP.
- RESP:
  - bus_valid = 0; wait for bus_rvalid, capture bus_rdata, go to DONE.
  - No timeout.
- DONE:
  - stall = 0.
  - load_valid = 1 for loads; load_data is registered and holds until the next load.
  - Unconditionally go to IDLE, so the op visible this cycle is never retriggered.
- bus_rvalid outside RESP/REQ is ignored.
- Address and data formatting:
  - bus_addr = {addr[31:2], 2'b00}.
  - bus_wstrb = (mask << addr[1:0]) truncated to 4 bits.
  - bus_wdata: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
- Load extraction:
  - Form sh = bus_rdata >> (8*addr[1:0]), zero-filled.
  - BYTE: sign-extend sh[7:0]. B_U: zero-extend sh[7:0].
  - HALF: sign-extend sh[15:0]. H_U: zero-extend sh[15:0].
  - WORD: sh.
- Latency with zero-wait bus:
  - Store: 2 stall cycles (IDLE, REQ).
  - Load with rvalid one cycle after ready: 3 stall cycles.
- Reset mid-transaction: return to IDLE next edge, bus_valid drops; any later rvalid is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Misaligned access: half with addr[0] = 1, or word with addr[1:0] != 00.
- With the macro:
  - A misaligned access issues no bus request; IDLE goes straight to DONE.
  - Adds output misalign_trap (1 bit), pulsed high in DONE; load_valid stays 0.
  - The trap cause is held in the latched registers for the trap handler.
- Without the macro:
  - No port is added; misaligned accesses proceed.
  - Strobe and data are truncated per the shift rules above (e.g. word at offset 2 writes lanes 2..3 only).

Decomposition:
- Shared defines include: MEM_RD_* and MEM_WR_* encodings, LSU state encodings (2 bits), and the bus strobe width.
- One natural sub-module, lsu_load_align: combinational shift and sign/zero extension of bus_rdata, reused by any future cache path.
- The FSM and store formatting stay in lsu_bus_adapter.

Test Plan:
- sb at addr 0x1003, wdata 0x000000A5, ready held 1 -> bus_addr 0x1000, wstrb 1000, wdata 0xA5A5A5A5, we = 1; stall high exactly 2 cycles.
- lb at addr 0x2001, rdata 0x0000_80FF_00 ... i.e. 0x00008000 with rvalid one cycle after ready -> load_data 0xFFFFFF80, load_valid one pulse; stall 3 cycles.
- lhu at addr 0x2002, rdata 0xBEEF1234, ready delayed 4 cycles -> bus_valid and address stable for 4 cycles, then load_data 0x0000BEEF.
- sw at 0x3000 with rst asserted in REQ -> next cycle bus_valid = 0, stall = 0; a later rvalid pulse changes nothing.
- lw at 0x4002:
  - With LSU_MISALIGN_TRAP_EN: no bus_valid, misalign_trap pulses 1 cycle.
  - Without it: bus_addr 0x4000, load_data = rdata >> 16.
- Back-to-back lw then sw with zero-wait bus -> the second op starts the cycle after DONE; no duplicate request for the first op.

Source files
------------

// File: rtl/lsu_bus_adapter_pkg.sv
// Shared encodings for the load/store bus adapter.
//   MEM_RD_*   : decoder load-type encodings (3 bits)
//   MEM_WR_*   : unshifted store lane masks (4 bits)
//   lsu_state_e: adapter FSM states (2 bits)
//   LSU_STRB_W : bus byte-strobe width
//   lsu_misaligned(): misaligned-access test, used when LSU_MISALIGN_TRAP_EN is defined
package lsu_bus_adapter_pkg;

    localparam logic [2:0] MEM_RD_NONE = 3'd0;
    localparam logic [2:0] MEM_RD_BYTE = 3'd1;
    localparam logic [2:0] MEM_RD_HALF = 3'd2;
    localparam logic [2:0] MEM_RD_WORD = 3'd3;
    localparam logic [2:0] MEM_RD_B_U  = 3'd4;
    localparam logic [2:0] MEM_RD_H_U  = 3'd5;

    localparam logic [3:0] MEM_WR_NONE = 4'b0000;
    localparam logic [3:0] MEM_WR_BYTE = 4'b0001;
    localparam logic [3:0] MEM_WR_HALF = 4'b0011;
    localparam logic [3:0] MEM_WR_WORD = 4'b1111;

    localparam int LSU_STRB_W = 4;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_RESP = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // A read type, when present, decides the access size; the mask is ignored.
    function automatic logic lsu_misaligned(logic [2:0] rt, logic [3:0] mk, logic [1:0] off);
        logic half, word;
        if (rt != MEM_RD_NONE) begin
            half = (rt == MEM_RD_HALF) || (rt == MEM_RD_H_U);
            word = (rt == MEM_RD_WORD);
        end else begin
            half = (mk == MEM_WR_HALF);
            word = (mk == MEM_WR_WORD);
        end
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the bus word down by the byte offset (zero
// fill) and sign/zero-extends according to the load type.
//   rdata_i : raw bus read word
//   rtype_i : MEM_RD_* load type
//   off_i   : byte offset addr[1:0]
//   data_o  : extended result (0 for MEM_RD_NONE / unused codes)
module lsu_load_align
    import lsu_bus_adapter_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  rtype_i,
    input  logic [1:0]  off_i,
    output logic [31:0] data_o
);

    logic [31:0] sh;

    always_comb begin
        sh = rdata_i >> {off_i, 3'b000};
        case (rtype_i)
            MEM_RD_BYTE: data_o = {{24{sh[7]}}, sh[7:0]};
            MEM_RD_B_U:  data_o = {24'h0, sh[7:0]};
            MEM_RD_HALF: data_o = {{16{sh[15]}}, sh[15:0]};
            MEM_RD_H_U:  data_o = {16'h0, sh[15:0]};
            MEM_RD_WORD: data_o = sh;
            default:     data_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_bus_adapter.sv
// Load/store unit bus adapter. Latches one decoder op, runs a valid/ready
// request on the data bus, waits for read data and returns the extended
// load result, holding the core stalled while the access is in flight.
//   clk, rst        : clock, synchronous active-high reset
//   mem_read_type   : decoder load type (MEM_RD_*)
//   mem_write_mask  : unshifted store mask (MEM_WR_*)
//   addr, wdata     : effective address, store data
//   stall           : pipeline freeze
//   load_data/valid : extended load result, one-cycle valid pulse
//   bus_*           : data-memory request/response channel
//   misalign_trap   : only when LSU_MISALIGN_TRAP_EN is defined; pulses in
//                     DONE for a misaligned access that was not issued
module lsu_bus_adapter
    import lsu_bus_adapter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            mem_read_type,
    input  logic [3:0]            mem_write_mask,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic                  stall,
    output logic [DATA_W-1:0]     load_data,
    output logic                  load_valid,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [LSU_STRB_W-1:0] bus_wstrb,
    output logic                  bus_we,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    input  logic [DATA_W-1:0]     bus_rdata,
    input  logic                  bus_rvalid
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_trap
`endif
);

    lsu_state_e        state_q;
    logic [2:0]        type_q;
    logic [3:0]        mask_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] ld_q;
    logic              mis_q;
    logic [DATA_W-1:0] ld_d;
    logic              is_rd_in, op_in, mis_in, is_load_q;

    assign is_rd_in  = (mem_read_type != MEM_RD_NONE);
    assign op_in     = is_rd_in || (mem_write_mask != MEM_WR_NONE);
    assign is_load_q = (type_q != MEM_RD_NONE);

`ifdef LSU_MISALIGN_TRAP_EN
    assign mis_in = lsu_misaligned(mem_read_type, mem_write_mask, addr[1:0]);
`else
    assign mis_in = 1'b0;
`endif

    lsu_load_align u_align (
        .rdata_i (bus_rdata),
        .rtype_i (type_q),
        .off_i   (addr_q[1:0]),
        .data_o  (ld_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            type_q  <= MEM_RD_NONE;
            mask_q  <= MEM_WR_NONE;
            addr_q  <= '0;
            wdata_q <= '0;
            ld_q    <= '0;
            mis_q   <= 1'b0;
        end else begin
            case (state_q)
                LSU_IDLE: begin
                    if (op_in) begin
                        type_q  <= mem_read_type;
                        // Loads win over a simultaneous mask; a zero mask
                        // also makes strobes and bus_we read as a load.
                        mask_q  <= is_rd_in ? MEM_WR_NONE : mem_write_mask;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        mis_q   <= mis_in;
                        state_q <= mis_in ? LSU_DONE : LSU_REQ;
                    end
                end
                LSU_REQ: begin
                    if (bus_ready) begin
                        if (!is_load_q) begin
                            state_q <= LSU_DONE;
                        end else if (bus_rvalid) begin
                            ld_q    <= ld_d;
                            state_q <= LSU_DONE;
                        end else begin
                            state_q <= LSU_RESP;
                        end
                    end
                end
                LSU_RESP: begin
                    if (bus_rvalid) begin
                        ld_q    <= ld_d;
                        state_q <= LSU_DONE;
                    end
                end
                // The decoder still shows this op during DONE; returning to
                // IDLE unconditionally keeps it from being issued twice.
                default: state_q <= LSU_IDLE;
            endcase
        end
    end

    // Only the IDLE term is combinational; it is masked during reset so
    // every output reads 0 while rst is held.
    assign stall = !rst && (((state_q == LSU_IDLE) && op_in) ||
                            (state_q == LSU_REQ) || (state_q == LSU_RESP));

    assign bus_valid  = (state_q == LSU_REQ);
    assign bus_addr   = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus_we     = (mask_q != MEM_WR_NONE);
    // Upper lanes shifted past bit 3 are dropped, so a misaligned store
    // only writes the lanes that fit in this word.
    assign bus_wstrb  = mask_q << addr_q[1:0];
    assign load_data  = ld_q;
    assign load_valid = (state_q == LSU_DONE) && is_load_q && !mis_q;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_trap = (state_q == LSU_DONE) && mis_q;
`endif

    always_comb begin
        case (mask_q)
            MEM_WR_BYTE: bus_wdata = {4{wdata_q[7:0]}};
            MEM_WR_HALF: bus_wdata = {2{wdata_q[15:0]}};
            default:     bus_wdata = wdata_q;
        endcase
    end

endmodule

// File: tb/tb_lsu_bus_adapter.sv
module tb_lsu_bus_adapter;
    import lsu_bus_adapter_pkg::*;

    logic        clk, rst;
    logic [2:0]  mem_read_type;
    logic [3:0]  mem_write_mask;
    logic [31:0] addr, wdata;
    logic        stall, load_valid, bus_we, bus_valid, bus_ready, bus_rvalid;
    logic [31:0] load_data, bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_wstrb;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign_trap;
`endif

    lsu_bus_adapter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .mem_read_type(mem_read_type), .mem_write_mask(mem_write_mask),
        .addr(addr), .wdata(wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
        .bus_we(bus_we), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid)
`ifdef LSU_MISALIGN_TRAP_EN
        , .misalign_trap(misalign_trap)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    logic [31:0] last_ld;

    // Observations of one op
    int          o_stall, o_vcnt, o_lv, o_trap;
    bit          o_done, o_stable;
    logic [31:0] o_addr, o_wdata, o_ld;
    logic [3:0]  o_wstrb;
    logic        o_we;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one op at the start of a cycle and act as the bus slave:
    // ready after rdly waiting cycles, rvalid vdly cycles after acceptance.
    // Returns after sampling the first non-stalled cycle (DONE).
    task automatic run_op(input logic [2:0] rt, input logic [3:0] mk, input logic [31:0] ad,
                          input logic [31:0] wd, input logic [31:0] rd, input int rdly, input int vdly);
        bit acc;
        int since;
        @(posedge clk); #1;
        mem_read_type = rt; mem_write_mask = mk; addr = ad; wdata = wd; bus_rdata = rd;
        bus_ready = 1'b0; bus_rvalid = 1'b0;
        o_stall = 0; o_vcnt = 0; o_lv = 0; o_trap = 0; o_done = 0; o_stable = 1;
        o_addr = '0; o_wdata = '0; o_wstrb = '0; o_we = 1'b0; o_ld = load_data;
        acc = 0; since = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            #1;
            if (stall) o_stall++;
            if (bus_valid) begin
                if (o_vcnt == 0) begin
                    o_addr = bus_addr; o_wdata = bus_wdata; o_wstrb = bus_wstrb; o_we = bus_we;
                end else if (bus_addr !== o_addr || bus_wdata !== o_wdata ||
                             bus_wstrb !== o_wstrb || bus_we !== o_we) begin
                    o_stable = 0;
                end
                o_vcnt++;
            end
            if (load_valid) o_lv++;
            o_ld = load_data;
`ifdef LSU_MISALIGN_TRAP_EN
            if (misalign_trap) o_trap++;
`endif
            if (cyc > 0 && !stall) begin
                o_done = 1;
                break;
            end
            bus_ready  = bus_valid && (o_vcnt > rdly);
            bus_rvalid = 1'b0;
            if (rt != MEM_RD_NONE) begin
                if (acc) begin
                    since++;
                    if (since == vdly) bus_rvalid = 1'b1;
                end else if (bus_ready) begin
                    acc = 1;
                    since = 0;
                    if (vdly == 0) bus_rvalid = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        bus_ready = 1'b0; bus_rvalid = 1'b0;
    endtask

    task automatic idle(input string nm, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            mem_read_type = MEM_RD_NONE; mem_write_mask = 4'b0000;
            #1;
            chk($sformatf("%s.idle_valid", nm), 32'(bus_valid), 32'd0);
            chk($sformatf("%s.idle_stall", nm), 32'(stall), 32'd0);
            chk($sformatf("%s.idle_lv", nm), 32'(load_valid), 32'd0);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] m_load(input logic [2:0] rt, input logic [31:0] rd, input int off);
        int unsigned sh, b, h;
        sh = rd >> (8 * off);
        b  = sh % 256;
        h  = sh % 65536;
        case (rt)
            MEM_RD_BYTE: return (b >= 128) ? b - 256 : b;
            MEM_RD_B_U:  return b;
            MEM_RD_HALF: return (h >= 32768) ? h - 65536 : h;
            MEM_RD_H_U:  return h;
            default:     return sh;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] mk, input logic [31:0] w);
        if (mk == 4'b0001) return (w % 256) * 32'h01010101;
        if (mk == 4'b0011) return (w % 65536) * 32'h00010001;
        return w;
    endfunction

    function automatic bit m_mis(input logic [2:0] rt, input logic [3:0] mk, input int off);
`ifdef LSU_MISALIGN_TRAP_EN
        int size;
        if (rt != MEM_RD_NONE) size = (rt == MEM_RD_WORD) ? 4 : (rt == MEM_RD_HALF || rt == MEM_RD_H_U) ? 2 : 1;
        else size = (mk == 4'b1111) ? 4 : (mk == 4'b0011) ? 2 : 1;
        return (off % size) != 0;
`else
        return 0;
`endif
    endfunction

    task automatic do_op(input string nm, input logic [2:0] rt, input logic [3:0] mk, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [31:0] rd, input int rdly, input int vdly);
        bit is_ld, mis;
        int off, e_stall;
        logic [31:0] e_ld;
        is_ld = (rt != MEM_RD_NONE);
        off   = int'(ad % 4);
        mis   = m_mis(rt, mk, off);
        e_ld  = (is_ld && !mis) ? m_load(rt, rd, off) : last_ld;
        e_stall = mis ? 1 : 1 + (rdly + 1) + (is_ld ? vdly : 0);
        run_op(rt, mk, ad, wd, rd, rdly, vdly);
        chk({nm, ".done"}, 32'(o_done), 32'd1);
        chk({nm, ".stall"}, o_stall, e_stall);
        chk({nm, ".vcnt"}, o_vcnt, mis ? 0 : rdly + 1);
        chk({nm, ".lv"}, o_lv, (is_ld && !mis) ? 1 : 0);
        chk({nm, ".ld"}, o_ld, e_ld);
`ifdef LSU_MISALIGN_TRAP_EN
        chk({nm, ".trap"}, o_trap, mis ? 1 : 0);
`endif
        if (!mis) begin
            chk({nm, ".addr"}, o_addr, ad - (ad % 4));
            chk({nm, ".strb"}, 32'(o_wstrb), is_ld ? 0 : (32'(mk) << off) % 16);
            chk({nm, ".we"}, 32'(o_we), is_ld ? 0 : 1);
            chk({nm, ".stable"}, 32'(o_stable), 32'd1);
            if (!is_ld) chk({nm, ".wdata"}, o_wdata, m_wdata(mk, wd));
        end
        if (is_ld && !mis) last_ld = e_ld;
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]  rt;
        logic [3:0]  mk;
        logic [31:0] ad, wd, rd;
        int          rdly, vdly;
        logic [31:0] e_addr;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata;
        logic        e_we;
        logic [31:0] e_ld;
        int          e_stall;
    } vec_t;

    vec_t tv[10];

    initial begin
        logic [31:0] e_ld;
        logic [2:0]  rt;
        logic [3:0]  mk;
        logic [3:0]  masks[3];

        tv[0] = '{3'd0,        4'b0001, 32'h1003, 32'h000000A5, 32'h0,        0, 0, 32'h1000, 4'b1000, 32'hA5A5A5A5, 1'b1, 32'h0,        2};
        tv[1] = '{MEM_RD_BYTE, 4'b0000, 32'h2001, 32'h0,        32'h00008000, 0, 1, 32'h2000, 4'b0000, 32'h0,        1'b0, 32'hFFFFFF80, 3};
        tv[2] = '{MEM_RD_H_U,  4'b0000, 32'h2002, 32'h0,        32'hBEEF1234, 4, 1, 32'h2000, 4'b0000, 32'h0,        1'b0, 32'h0000BEEF, 7};
        tv[3] = '{3'd0,        4'b0011, 32'h1002, 32'h1234ABCD, 32'h0,        0, 0, 32'h1000, 4'b1100, 32'hABCDABCD, 1'b1, 32'h0,        2};
        tv[4] = '{3'd0,        4'b1111, 32'h3000, 32'hDEADBEEF, 32'h0,        2, 0, 32'h3000, 4'b1111, 32'hDEADBEEF, 1'b1, 32'h0,        4};
        tv[5] = '{MEM_RD_HALF, 4'b0000, 32'h0010, 32'h0,        32'h00008001, 0, 0, 32'h0010, 4'b0000, 32'h0,        1'b0, 32'hFFFF8001, 2};
        tv[6] = '{MEM_RD_B_U,  4'b0000, 32'h0013, 32'h0,        32'h9A000000, 0, 1, 32'h0010, 4'b0000, 32'h0,        1'b0, 32'h0000009A, 3};
        tv[7] = '{MEM_RD_WORD, 4'b0000, 32'h0020, 32'h0,        32'h12345678, 1, 2, 32'h0020, 4'b0000, 32'h0,        1'b0, 32'h12345678, 5};
        tv[8] = '{MEM_RD_WORD, 4'b1111, 32'h0040, 32'hFFFFFFFF, 32'h0BADF00D, 0, 1, 32'h0040, 4'b0000, 32'h0,        1'b0, 32'h0BADF00D, 3};
        tv[9] = '{3'd0,        4'b0001, 32'h0044, 32'h12345677, 32'h0,        0, 0, 32'h0044, 4'b0001, 32'h77777777, 1'b1, 32'h0,        2};

        // ---- reset state ----
        rst = 1'b1; mem_read_type = 3'd0; mem_write_mask = 4'd0; addr = '0; wdata = '0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.valid", 32'(bus_valid), 32'd0);
        chk("rst.lv", 32'(load_valid), 32'd0);
        chk("rst.ld", load_data, 32'd0);
        chk("rst.addr", bus_addr, 32'd0);
        chk("rst.strb", 32'(bus_wstrb), 32'd0);
        chk("rst.we", 32'(bus_we), 32'd0);
        chk("rst.wdata", bus_wdata, 32'd0);
        mem_read_type = MEM_RD_WORD;
        #1;
        chk("rst.stall_op", 32'(stall), 32'd0);
        mem_read_type = MEM_RD_NONE;
        @(posedge clk); #1;
        rst = 1'b0;
        last_ld = 32'h0;

        // ---- table ----
        for (int i = 0; i < 10; i++) begin
            run_op(tv[i].rt, tv[i].mk, tv[i].ad, tv[i].wd, tv[i].rd, tv[i].rdly, tv[i].vdly);
            e_ld = (tv[i].rt != MEM_RD_NONE) ? tv[i].e_ld : last_ld;
            chk($sformatf("tv%0d.done", i), 32'(o_done), 32'd1);
            chk($sformatf("tv%0d.stall", i), o_stall, tv[i].e_stall);
            chk($sformatf("tv%0d.vcnt", i), o_vcnt, tv[i].rdly + 1);
            chk($sformatf("tv%0d.stable", i), 32'(o_stable), 32'd1);
            chk($sformatf("tv%0d.addr", i), o_addr, tv[i].e_addr);
            chk($sformatf("tv%0d.strb", i), 32'(o_wstrb), 32'(tv[i].e_strb));
            chk($sformatf("tv%0d.we", i), 32'(o_we), 32'(tv[i].e_we));
            if (tv[i].e_we) chk($sformatf("tv%0d.wdata", i), o_wdata, tv[i].e_wdata);
            chk($sformatf("tv%0d.lv", i), o_lv, (tv[i].rt != MEM_RD_NONE) ? 1 : 0);
            chk($sformatf("tv%0d.ld", i), o_ld, e_ld);
            last_ld = e_ld;
        end
        idle("tv", 2);

        // ---- lw at 0x4002 (misaligned word) ----
        do_op("lw4002", MEM_RD_WORD, 4'b0000, 32'h4002, 32'h0, 32'hCAFE0000, 0, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw4002.no_req", o_vcnt, 0);
        chk("lw4002.trap_pulse", o_trap, 1);
`else
        chk("lw4002.bus_addr", o_addr, 32'h4000);
        chk("lw4002.data", o_ld, 32'h0000CAFE);
`endif
        idle("lw4002", 1);

        // ---- reset while a store sits in REQ ----
        @(posedge clk); #1;
        mem_write_mask = 4'b1111; addr = 32'h3000; wdata = 32'h55AA55AA; bus_ready = 1'b0;
        @(posedge clk); #1;
        chk("rstmid.in_req", 32'(bus_valid), 32'd1);
        rst = 1'b1; mem_write_mask = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rstmid.valid", 32'(bus_valid), 32'd0);
        chk("rstmid.stall", 32'(stall), 32'd0);
        bus_rvalid = 1'b1; bus_rdata = 32'h87654321;
        @(posedge clk); #1;
        bus_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rstmid.late_lv", 32'(load_valid), 32'd0);
            chk("rstmid.late_ld", load_data, 32'd0);
            chk("rstmid.late_valid", 32'(bus_valid), 32'd0);
            chk("rstmid.late_stall", 32'(stall), 32'd0);
            @(posedge clk); #1;
        end
        last_ld = 32'h0;

        // ---- back-to-back load then store, zero-wait bus ----
        do_op("b2b.lw", MEM_RD_WORD, 4'b0000, 32'h0050, 32'h0, 32'h11223344, 0, 1);
        do_op("b2b.sw", 3'd0, 4'b1111, 32'h0054, 32'hA1B2C3D4, 32'h0, 0, 0);
        idle("b2b", 3);

        // ---- randomized ops against the model ----
        masks[0] = 4'b0001; masks[1] = 4'b0011; masks[2] = 4'b1111;
        for (int i = 0; i < 150; i++) begin
            rt = 3'($urandom_range(0, 5));
            mk = masks[$urandom_range(0, 2)];
            if (rt != MEM_RD_NONE && $urandom_range(0, 3) != 0) mk = 4'b0000;
            do_op($sformatf("rnd%0d", i), rt, mk, $urandom, $urandom, $urandom,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 2) == 0) idle($sformatf("rnd%0d", i), int'($urandom_range(1, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
